hearts_hud_controller: RTL and testbench

- Lives/HUD controller that drives the shared 32x32 heart bitmap for a row of up to MAX_LIVES heart icons in the top HUD.
- Tracks the life count from game events and maps the current VGA pixel to a heart slot, producing the bitmap's offsetX, offsetY and InsideRectangle.
- Sequences a blink animation on the heart being lost, then raises gameOver when the last life is gone.

---
 rtl/hud_pkg.sv | 18 +
 rtl/hud_frame_timer.sv | 52 +++++
 rtl/hearts_hud_controller.sv | 160 ++++++++++++++++
 tb/tb_hearts_hud_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared types and constants for the hearts HUD controller
// Contents:
//   HEART_SIZE_BITS : log2 of the heart bitmap edge (32 px)
//   hud_state_t     : life/HUD FSM states
//   lives_t         : life count type
package hud_pkg;

  localparam int HEART_SIZE_BITS = 5;

  typedef enum logic [1:0] {
    ALIVE,
    HIT_BLINK,
    GAME_OVER
  } hud_state_t;

  typedef logic [2:0] lives_t;

endpackage

// File: rtl/hud_frame_timer.sv
// rtl/hud_frame_timer.sv - frame-based blink sequencer for the heart being lost
// Ports:
//   clk      : pixel clock
//   reset    : synchronous active-high reset
//   start    : clears the counters and restarts the blink at phase "on"
//   enable   : counting is allowed (blink animation active)
//   sof      : one-cycle start-of-frame pulse
//   blink_on : current blink phase, starts at 1, toggles every BLINK_HALF frames
//   done     : combinational pulse on the frame that completes BLINK_FRAMES frames
module hud_frame_timer #(
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic enable,
  input  logic sof,
  output logic blink_on,
  output logic done
);

  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam int HW = $clog2(BLINK_HALF + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(BLINK_HALF - 1);

  logic [CW-1:0] frame_cnt;
  logic [HW-1:0] half_cnt;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      frame_cnt <= '0;
      half_cnt  <= '0;
      blink_on  <= 1'b1;
    end else if (enable && sof) begin
      if (frame_cnt != FRAME_LAST + 1'b1) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        blink_on <= ~blink_on;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

  // A start in the same cycle wins, so a fresh blink is never cut short.
  assign done = enable && sof && !start && (frame_cnt == FRAME_LAST);

endmodule

// File: rtl/hearts_hud_controller.sv
// rtl/hearts_hud_controller.sv - lives tracking, heart-row pixel mapping and blink/game-over FSM
// Optional feature macro: HEARTS_LOW_LIFE_PULSE_EN (last heart pulses 16 on / 16 off frames)
// Ports:
//   clk, resetN (sync, active-high)      : clock / reset
//   pixelX, pixelY                       : current VGA pixel
//   startOfFrame                         : one-cycle pulse per frame
//   lifeLost, lifeGained, restart        : one-cycle game events
//   offsetX, offsetY, InsideRectangle    : registered heart bitmap addressing
//   lives, gameOver                      : registered life count and game-over level
module hearts_hud_controller
  import hud_pkg::*;
#(
  parameter int MAX_LIVES    = 5,
  parameter int START_LIVES  = 3,
  parameter int TOP_LEFT_X   = 16,
  parameter int TOP_LEFT_Y   = 8,
  parameter int PITCH_BITS   = 6,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        lifeLost,
  input  logic        lifeGained,
  input  logic        restart,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [2:0]  lives,
  output logic        gameOver
);

  localparam int SW = 11 - PITCH_BITS;
  localparam logic [10:0] ROW_END   = 11'(MAX_LIVES << PITCH_BITS);
  localparam logic [10:0] HEART_LIM = 11'(1 << HEART_SIZE_BITS);
  localparam lives_t      MAX_L     = 3'(MAX_LIVES);
  localparam lives_t      START_L   = 3'(START_LIVES);

  hud_state_t state;

  logic [10:0]   rel_x;
  logic [10:0]   rel_y;
  logic [SW-1:0] slot;
  logic          in_heart;
  logic          visible;
  logic          blink_on;
  logic          timer_done;
  logic          go_blink;
  logic          can_gain;
  lives_t        lives_gain;
  logic          low_life_hide;

  // Negative differences wrap to large values and fail the range tests.
  assign rel_x = pixelX - 11'(TOP_LEFT_X);
  assign rel_y = pixelY - 11'(TOP_LEFT_Y);
  assign slot  = rel_x[10:PITCH_BITS];

  assign in_heart = (rel_x < ROW_END) &&
                    (rel_x[PITCH_BITS-1:HEART_SIZE_BITS] == '0) &&
                    (rel_y < HEART_LIM);

  assign go_blink   = (state == ALIVE) && lifeLost && !lifeGained && (lives != '0);
  assign can_gain   = lifeGained && (lives < MAX_L);
  assign lives_gain = can_gain ? lives + 1'b1 : lives;

`ifdef HEARTS_LOW_LIFE_PULSE_EN
  logic [4:0] free_cnt;

  always_ff @(posedge clk) begin
    if (resetN) begin
      free_cnt <= '0;
    end else if (startOfFrame) begin
      free_cnt <= free_cnt + 1'b1;
    end
  end

  assign low_life_hide = (state == ALIVE) && (lives == 3'd1) && free_cnt[4];
`else
  assign low_life_hide = 1'b0;
`endif

  // The blinking slot sits just past the solid ones, at index == lives.
  assign visible = ((slot < SW'(lives)) && !(low_life_hide && (slot == '0))) ||
                   ((state == HIT_BLINK) && (slot == SW'(lives)) && blink_on);

  hud_frame_timer #(
    .BLINK_FRAMES(BLINK_FRAMES),
    .BLINK_HALF  (BLINK_HALF)
  ) u_timer (
    .clk     (clk),
    .reset   (resetN),
    .start   (restart || go_blink),
    .enable  (state == HIT_BLINK),
    .sof     (startOfFrame),
    .blink_on(blink_on),
    .done    (timer_done)
  );

  always_ff @(posedge clk) begin
    if (resetN) begin
      state    <= ALIVE;
      lives    <= START_L;
      gameOver <= 1'b0;
    end else if (restart) begin
      state    <= ALIVE;
      lives    <= START_L;
      gameOver <= 1'b0;
    end else begin
      case (state)
        ALIVE: begin
          if (go_blink) begin
            lives <= lives - 1'b1;
            state <= HIT_BLINK;
          end else if (can_gain && !lifeLost) begin
            lives <= lives_gain;
          end
        end
        HIT_BLINK: begin
          // Invulnerable: lifeLost ignored, lifeGained still counts.
          lives <= lives_gain;
          if (timer_done) begin
            if (lives_gain == '0) begin
              state    <= GAME_OVER;
              gameOver <= 1'b1;
            end else begin
              state <= ALIVE;
            end
          end
        end
        GAME_OVER: begin
          gameOver <= 1'b1;
        end
        default: begin
          state    <= ALIVE;
          gameOver <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
    end else if (in_heart && visible && (state != GAME_OVER)) begin
      offsetX         <= 11'(rel_x[HEART_SIZE_BITS-1:0]);
      offsetY         <= 11'(rel_y[HEART_SIZE_BITS-1:0]);
      InsideRectangle <= 1'b1;
    end else begin
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hearts_hud_controller.sv
// tb/tb_hearts_hud_controller.sv - directed self-checking bench for hearts_hud_controller
module tb_hearts_hud_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        lifeLost = 1'b0;
  logic        lifeGained = 1'b0;
  logic        restart = 1'b0;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic [2:0]  lives;
  logic        gameOver;

  int checks = 0;
  int errors = 0;
  int sof_count = 0;

  hearts_hud_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .startOfFrame   (startOfFrame),
    .lifeLost       (lifeLost),
    .lifeGained     (lifeGained),
    .restart        (restart),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .lives          (lives),
    .gameOver       (gameOver)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    sof_count++;
  endtask

  task automatic lose();
    lifeLost = 1'b1;
    step();
    lifeLost = 1'b0;
  endtask

  task automatic gain();
    lifeGained = 1'b1;
    step();
    lifeGained = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    step();
    sof_count = 0;
  endtask

  initial begin
    // 1. reset state and basic geometry
    resetN = 1'b1;
    step();
    step();
    check("rst_lives", lives, 3);
    check("rst_gameover", gameOver, 0);
    check("rst_inside", InsideRectangle, 0);
    check("rst_offx", offsetX, 0);
    check("rst_offy", offsetY, 0);
    resetN = 1'b0;
    sof_count = 0;

    probe(16, 8);
    check("s0_inside", InsideRectangle, 1);
    check("s0_offx", offsetX, 0);
    check("s0_offy", offsetY, 0);
    probe(16 + 128 + 5, 10);
    check("s2_inside", InsideRectangle, 1);
    check("s2_offx", offsetX, 5);
    check("s2_offy", offsetY, 2);
    probe(16 + 192, 8);
    check("s3_hidden", InsideRectangle, 0);
    check("s3_offx", offsetX, 0);

    // 2. gap and edges
    probe(16 + 40, 8);
    check("gap", InsideRectangle, 0);
    probe(15, 8);
    check("left_edge", InsideRectangle, 0);
    probe(16, 40);
    check("bottom_edge", InsideRectangle, 0);
    probe(16 + 31, 8 + 31);
    check("corner_inside", InsideRectangle, 1);
    check("corner_offx", offsetX, 31);
    check("corner_offy", offsetY, 31);

    // 3. blink on slot 2
    lose();
    check("lost_lives", lives, 2);
    probe(16 + 128, 8);
    check("blink_f0", InsideRectangle, 1);
    repeat (7) frame();
    probe(16 + 128, 8);
    check("blink_f7", InsideRectangle, 1);
    frame();
    probe(16 + 128, 8);
    check("blink_f8", InsideRectangle, 0);
    lose();
    check("invuln_lives", lives, 2);
    repeat (8) frame();
    probe(16 + 128, 8);
    check("blink_f16", InsideRectangle, 1);
    repeat (43) frame();
    probe(16 + 128, 8);
    check("blink_f59", InsideRectangle, 0);
    frame();
    probe(16 + 128, 8);
    check("after_blink_hidden", InsideRectangle, 0);
    repeat (8) frame();
    probe(16 + 128, 8);
    check("alive_no_blink", InsideRectangle, 0);
    lose();
    check("alive_again_lose", lives, 1);
    repeat (60) frame();
    probe(16, 8);
    check("one_life_s0", InsideRectangle, 1);
    probe(16 + 64, 8);
    check("one_life_s1", InsideRectangle, 0);

    // 4. cancel and saturation
    lifeLost = 1'b1;
    lifeGained = 1'b1;
    step();
    lifeLost = 1'b0;
    lifeGained = 1'b0;
    check("cancel_lives", lives, 1);
    probe(16 + 64, 8);
    check("cancel_no_blink", InsideRectangle, 0);
    gain();
    gain();
    check("gain_to3", lives, 3);
    repeat (5) gain();
    check("gain_sat", lives, 5);
    probe(16 + 256 + 3, 8);
    check("s4_inside", InsideRectangle, 1);
    check("s4_offx", offsetX, 3);
    do_restart();
    check("restart_lives", lives, 3);

    // 5. lose everything
    repeat (3) begin
      lose();
      repeat (60) frame();
    end
    step();
    check("go_level", gameOver, 1);
    check("go_lives", lives, 0);
    probe(16, 8);
    check("go_inside", InsideRectangle, 0);
    gain();
    check("go_gain_ignored", lives, 0);
    do_restart();
    check("go_restart_lives", lives, 3);
    check("go_restart_level", gameOver, 0);

    // 6. reset mid-blink, then timer restarts from frame 0
    lose();
    repeat (10) frame();
    do_reset();
    check("mid_rst_lives", lives, 3);
    check("mid_rst_gameover", gameOver, 0);
    check("mid_rst_inside", InsideRectangle, 0);
    check("mid_rst_offx", offsetX, 0);
    resetN = 1'b0;
    probe(16 + 128, 8);
    check("mid_rst_s2", InsideRectangle, 1);
    lose();
    repeat (7) frame();
    probe(16 + 128, 8);
    check("rst_blink_f7", InsideRectangle, 1);
    frame();
    probe(16 + 128, 8);
    check("rst_blink_f8", InsideRectangle, 0);
    repeat (52) frame();
    lose();
    check("rst_blink_end_lose", lives, 1);
    repeat (60) frame();

`ifdef HEARTS_LOW_LIFE_PULSE_EN
    probe(16, 8);
    check("pulse_a", InsideRectangle, (sof_count & 16) == 0 ? 1 : 0);
    repeat (16) frame();
    probe(16, 8);
    check("pulse_b", InsideRectangle, (sof_count & 16) == 0 ? 1 : 0);
    repeat (16) frame();
    probe(16, 8);
    check("pulse_c", InsideRectangle, (sof_count & 16) == 0 ? 1 : 0);
`else
    probe(16, 8);
    check("solid_a", InsideRectangle, 1);
    repeat (16) frame();
    probe(16, 8);
    check("solid_b", InsideRectangle, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
